dataflow_deadlock_monitor: RTL and testbench



---
 rtl/dl_monitor_pkg.sv | 25 ++
 rtl/dl_lsb_encoder.sv | 20 ++
 rtl/dataflow_deadlock_monitor.sv | 148 ++++++++++++++
 tb/tb_dataflow_deadlock_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dl_monitor_pkg.sv
// Shared types and helpers for the dataflow deadlock monitor.
package dl_monitor_pkg;

    localparam int unsigned TIMESTAMP_W = 32;

    typedef enum logic [1:0] {
        StWatch   = 2'd0,
        StStall   = 2'd1,
        StLatched = 2'd2
    } dl_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dl_lsb_encoder.sv
// Combinational lowest-set-bit index encoder; output is 0 for an all-zero vector.
module dl_lsb_encoder #(
    parameter int unsigned NUM_PROC = 13,
    parameter int unsigned IDX_W    = 4
) (
    input  logic [NUM_PROC-1:0] vec_i,
    output logic [IDX_W-1:0]    idx_o
);

    // Scan high to low so the last hit written is the lowest set bit.
    always_comb begin
        idx_o = '0;
        for (int i = int'(NUM_PROC) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// Deadlock monitor for one HLS dataflow region: flags a sticky deadlock once every process
// has been stopped for STALL_CYCLES consecutive cycles with at least one AXIS stall.
module dataflow_deadlock_monitor
    import dl_monitor_pkg::*;
#(
    parameter int unsigned         NUM_PROC       = 13,
    parameter logic [NUM_PROC-1:0] AXIS_PROC_MASK = NUM_PROC'(13'b1_0001_0000_0001),
    parameter int unsigned         STALL_CYCLES   = 16,
    parameter int unsigned         CNT_W          = clog2(STALL_CYCLES + 1),
    parameter int unsigned         IDX_W          = (clog2(NUM_PROC) < 1) ? 1 : clog2(NUM_PROC)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [NUM_PROC-1:0]    axis_block_sigs,
    input  logic [NUM_PROC-1:0]    inst_idle_sigs,
    input  logic [NUM_PROC-1:0]    inst_block_sigs,
    output logic                   block,
    output logic                   deadlock,
    output logic [CNT_W-1:0]       stall_count,
    output logic [NUM_PROC-1:0]    culprit_vec,
    output logic [IDX_W-1:0]       first_axis_idx,
    output logic [TIMESTAMP_W-1:0] deadlock_cycle
);

    localparam logic [CNT_W-1:0] StallMax  = CNT_W'(STALL_CYCLES);
    localparam logic [CNT_W-1:0] StallLast = CNT_W'(STALL_CYCLES - 1);

    dl_state_e              state_q, state_d;
    logic                   block_q, block_d;
    logic                   deadlock_q, deadlock_d;
    logic [CNT_W-1:0]       stall_q, stall_d;
    logic [NUM_PROC-1:0]    culprit_q, culprit_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TIMESTAMP_W-1:0] dl_cycle_q, dl_cycle_d;
    logic [TIMESTAMP_W-1:0] cycle_ctr_q, cycle_ctr_d;

    logic [NUM_PROC-1:0] axis_vec;
    logic [NUM_PROC-1:0] stopped;
    logic                cond;
    logic                capture;
    logic [IDX_W-1:0]    lsb_idx;

    assign axis_vec = axis_block_sigs & AXIS_PROC_MASK;
    assign stopped  = inst_idle_sigs | inst_block_sigs | axis_vec;
    assign cond     = enable & (|axis_vec) & (&stopped);

    dl_lsb_encoder #(
        .NUM_PROC (NUM_PROC),
        .IDX_W    (IDX_W)
    ) u_lsb_encoder (
        .vec_i (axis_vec),
        .idx_o (lsb_idx)
    );

    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        deadlock_d  = deadlock_q;
        culprit_d   = culprit_q;
        idx_d       = idx_q;
        dl_cycle_d  = dl_cycle_q;
        capture     = 1'b0;
        block_d     = cond;
        cycle_ctr_d = (enable && !(&cycle_ctr_q)) ? cycle_ctr_q + 1'b1 : cycle_ctr_q;

        unique case (state_q)
            StWatch: begin
                if (cond) begin
                    stall_d = CNT_W'(1);
                    if (STALL_CYCLES == 1) begin
                        capture = 1'b1;
                    end else begin
                        state_d = StStall;
                    end
                end else begin
                    stall_d = '0;
                end
            end
            StStall: begin
                if (!cond) begin
                    state_d = StWatch;
                    stall_d = '0;
                end else if (stall_q == StallLast) begin
                    capture = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            StLatched: begin
            end
            default: begin
                state_d = StWatch;
            end
        endcase

        // Captures all sample the inputs of the cycle that completes the stall run.
        if (capture) begin
            state_d    = StLatched;
            deadlock_d = 1'b1;
            stall_d    = StallMax;
            culprit_d  = axis_vec;
            idx_d      = lsb_idx;
            dl_cycle_d = cycle_ctr_q;
        end

        // Clear wins over a simultaneous detection.
        if (clear) begin
            state_d    = StWatch;
            deadlock_d = 1'b0;
            stall_d    = '0;
            culprit_d  = '0;
            idx_d      = '0;
            dl_cycle_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StWatch;
            block_q     <= 1'b0;
            deadlock_q  <= 1'b0;
            stall_q     <= '0;
            culprit_q   <= '0;
            idx_q       <= '0;
            dl_cycle_q  <= '0;
            cycle_ctr_q <= '0;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            deadlock_q  <= deadlock_d;
            stall_q     <= stall_d;
            culprit_q   <= culprit_d;
            idx_q       <= idx_d;
            dl_cycle_q  <= dl_cycle_d;
            cycle_ctr_q <= cycle_ctr_d;
        end
    end

    assign block          = block_q;
    assign deadlock       = deadlock_q;
    assign stall_count    = stall_q;
    assign culprit_vec    = culprit_q;
    assign first_axis_idx = idx_q;
    assign deadlock_cycle = dl_cycle_q;

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Bench for dataflow_deadlock_monitor: directed scenarios plus random traffic checked
// against a cycle-level behavioural model.
module tb_dataflow_deadlock_monitor;

    localparam int unsigned NP    = 13;
    localparam logic [12:0] MASK  = 13'b1_0001_0000_0001;
    localparam int unsigned SC    = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned IDX_W = 4;
    localparam logic [12:0] ALL   = 13'h1FFF;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             clear;
    logic [NP-1:0]    axis_block_sigs;
    logic [NP-1:0]    inst_idle_sigs;
    logic [NP-1:0]    inst_block_sigs;
    logic             block;
    logic             deadlock;
    logic [CNT_W-1:0] stall_count;
    logic [NP-1:0]    culprit_vec;
    logic [IDX_W-1:0] first_axis_idx;
    logic [31:0]      deadlock_cycle;

    dataflow_deadlock_monitor #(
        .NUM_PROC       (NP),
        .AXIS_PROC_MASK (MASK),
        .STALL_CYCLES   (SC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .clear           (clear),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block),
        .deadlock        (deadlock),
        .stall_count     (stall_count),
        .culprit_vec     (culprit_vec),
        .first_axis_idx  (first_axis_idx),
        .deadlock_cycle  (deadlock_cycle)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        m_block;
    logic        m_dl;
    int          m_run;
    logic [12:0] m_culprit;
    int          m_idx;
    logic [31:0] m_dlcyc;
    logic [31:0] m_ctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_cond();
        logic [12:0] av;
        logic        all_stopped;
        av          = axis_block_sigs & MASK;
        all_stopped = 1'b1;
        for (int i = 0; i < int'(NP); i++) begin
            if (!(inst_idle_sigs[i] || inst_block_sigs[i] || av[i])) all_stopped = 1'b0;
        end
        return enable && (av != 0) && all_stopped;
    endfunction

    function automatic int lowest_set(input logic [12:0] v);
        for (int i = 0; i < int'(NP); i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":block"}, 32'(block), 32'(m_block));
        chk({tag, ":deadlock"}, 32'(deadlock), 32'(m_dl));
        chk({tag, ":stall_count"}, 32'(stall_count), 32'(m_run));
        chk({tag, ":culprit_vec"}, 32'(culprit_vec), 32'(m_culprit));
        chk({tag, ":first_axis_idx"}, 32'(first_axis_idx), 32'(m_idx));
        chk({tag, ":deadlock_cycle"}, deadlock_cycle, m_dlcyc);
    endtask

    // Advance the model by one clock using the currently applied inputs, then compare.
    task automatic tick(input string tag);
        logic        c;
        logic [12:0] av;
        c  = model_cond();
        av = axis_block_sigs & MASK;
        if (reset) begin
            m_block = 0; m_dl = 0; m_run = 0; m_culprit = '0; m_idx = 0; m_dlcyc = '0;
            m_ctr = '0;
        end else begin
            m_block = c;
            if (clear) begin
                m_dl = 0; m_run = 0; m_culprit = '0; m_idx = 0; m_dlcyc = '0;
            end else if (m_dl) begin
                // latched: everything holds
            end else if (c) begin
                m_run++;
                if (m_run == int'(SC)) begin
                    m_dl      = 1;
                    m_culprit = av;
                    m_idx     = lowest_set(av);
                    m_dlcyc   = m_ctr;
                end
            end else begin
                m_run = 0;
            end
            if (enable && m_ctr != 32'hFFFF_FFFF) m_ctr++;
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic en, input logic clr, input logic [12:0] ax,
                         input logic [12:0] idl, input logic [12:0] blk);
        enable          = en;
        clear           = clr;
        axis_block_sigs = ax;
        inst_idle_sigs  = idl;
        inst_block_sigs = blk;
    endtask

    initial begin
        m_block = 0; m_dl = 0; m_run = 0; m_culprit = '0; m_idx = 0; m_dlcyc = '0; m_ctr = '0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 13'h0, 13'h0, 13'h0);
        tick("reset0");
        tick("reset1");
        chk("reset_deadlock", 32'(deadlock), 32'd0);
        chk("reset_stall", 32'(stall_count), 32'd0);
        reset = 1'b0;

        // 1: process 0 AXIS-blocked, others idle
        drive(1'b1, 1'b0, 13'h0001, 13'h1FFE, 13'h0);
        for (int i = 0; i < 4; i++) tick("t1_run");
        chk("t1_deadlock", 32'(deadlock), 32'd1);
        chk("t1_culprit", 32'(culprit_vec), 32'h0001);
        chk("t1_idx", 32'(first_axis_idx), 32'd0);
        chk("t1_cycle", deadlock_cycle, 32'd3);
        tick("t1_hold");
        clear = 1'b1; tick("t1_clear"); clear = 1'b0;
        axis_block_sigs = 13'h0; tick("t1_drop");

        // 2: broken run then a full run
        drive(1'b1, 1'b0, 13'h0001, 13'h1FFE, 13'h0);
        for (int i = 0; i < 3; i++) tick("t2_runa");
        inst_idle_sigs = 13'h1FDE;
        tick("t2_break");
        chk("t2_break_stall", 32'(stall_count), 32'd0);
        inst_idle_sigs = 13'h1FFE;
        for (int i = 0; i < 3; i++) tick("t2_runb");
        chk("t2_pre_deadlock", 32'(deadlock), 32'd0);
        tick("t2_runb_end");
        chk("t2_deadlock", 32'(deadlock), 32'd1);
        chk("t2_stall", 32'(stall_count), 32'd4);
        clear = 1'b1; tick("t2_clear"); clear = 1'b0;

        // 3: AXIS bit on an unmasked-off process is ignored
        drive(1'b1, 1'b0, 13'h0002, ALL, 13'h0);
        for (int i = 0; i < 20; i++) tick("t3_masked");
        chk("t3_block", 32'(block), 32'd0);
        chk("t3_deadlock", 32'(deadlock), 32'd0);

        // 4: processes 8 and 12 AXIS-blocked, clear, re-latch
        drive(1'b1, 1'b0, 13'h1100, 13'h0EFF, 13'h0);
        for (int i = 0; i < 4; i++) tick("t4_run");
        chk("t4_culprit", 32'(culprit_vec), 32'h1100);
        chk("t4_idx", 32'(first_axis_idx), 32'd8);
        clear = 1'b1; tick("t4_clear"); clear = 1'b0;
        chk("t4_clr_culprit", 32'(culprit_vec), 32'd0);
        chk("t4_clr_cycle", deadlock_cycle, 32'd0);
        for (int i = 0; i < 4; i++) tick("t4_relatch");
        chk("t4_relatched", 32'(deadlock), 32'd1);

        // 5: clear coincides with the would-be detecting cycle
        clear = 1'b1; axis_block_sigs = 13'h0; tick("t5_prep"); clear = 1'b0;
        axis_block_sigs = 13'h1100;
        for (int i = 0; i < 3; i++) tick("t5_run");
        clear = 1'b1; tick("t5_clash"); clear = 1'b0;
        chk("t5_deadlock", 32'(deadlock), 32'd0);
        chk("t5_stall", 32'(stall_count), 32'd0);

        // 6: reset mid-count, then disabled monitoring
        axis_block_sigs = 13'h0; tick("t6_prep");
        reset = 1'b1; tick("t6_reset_prep"); reset = 1'b0;
        axis_block_sigs = 13'h0001; inst_idle_sigs = 13'h1FFE;
        for (int i = 0; i < 2; i++) tick("t6_run");
        reset = 1'b1; tick("t6_reset"); reset = 1'b0;
        chk("t6_rst_block", 32'(block), 32'd0);
        chk("t6_rst_stall", 32'(stall_count), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick("t6_disabled");
        chk("t6_dis_block", 32'(block), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick("t6_enabled");
        chk("t6_cycle", deadlock_cycle, 32'd3);
        clear = 1'b1; tick("t6_clear"); clear = 1'b0;

        // Random traffic biased towards near-deadlock patterns
        for (int n = 0; n < 400; n++) begin
            logic [12:0] idl;
            idl = ALL;
            if ($urandom_range(0, 7) == 0) idl[$urandom_range(0, 12)] = 1'b0;
            reset           = ($urandom_range(0, 99) == 0);
            clear           = ($urandom_range(0, 39) == 0);
            enable          = ($urandom_range(0, 15) != 0);
            axis_block_sigs = 13'($urandom) & ((n % 50 < 25) ? ALL : 13'h1100);
            inst_idle_sigs  = idl & 13'($urandom | $urandom);
            inst_block_sigs = 13'($urandom);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
